// File: rtl/clk_period_meter_pkg.sv
// Shared types and default tuning for the slow-clock period meter.
// The defaults describe a 200 kHz clock measured with a 50 MHz system clock.
package clk_period_meter_pkg;

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      MEASURE    = 2'd1,
      LOST       = 2'd2
   } meter_state_t;

   localparam int DEF_CNT_W   = 16;
   localparam int DEF_EXP_PER = 250;
   localparam int DEF_TOL     = 2;
   localparam int DEF_LOCK_N  = 4;
   localparam int DEF_TMO_MAX = 1023;

   // The lower tolerance bound is clamped so that a tolerance wider than the period never wraps.
   function automatic int tol_lo(input int exp_per, input int tol);
      return (exp_per > tol) ? (exp_per - tol) : 0;
   endfunction

   function automatic int tol_hi(input int exp_per, input int tol);
      return exp_per + tol;
   endfunction

endpackage

// File: rtl/clk_period_meter_if.sv
// Bundle between the period meter and whoever feeds it the clock under test.
// master = the meter; slave = the source of CLK_IN and consumer of the results.
interface clk_period_meter_if
   import clk_period_meter_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);
   logic             CLK_IN;
   logic [7:0]       LED;
   logic [CNT_W-1:0] PERIOD;
   logic             PERIOD_VLD;
   logic             LOCK;
   logic             TIMEOUT;

   modport master (
      input  CLK_IN,
      output LED,
      output PERIOD,
      output PERIOD_VLD,
      output LOCK,
      output TIMEOUT
   );

   modport slave (
      output CLK_IN,
      input  LED,
      input  PERIOD,
      input  PERIOD_VLD,
      input  LOCK,
      input  TIMEOUT
   );
endinterface

// File: rtl/clk_period_meter_edge_sync_det.sv
// Multi-stage synchroniser plus rising-edge pulse for slow asynchronous inputs.
// Each bit gets its own chain so one instance can serve a group of buttons.
module edge_sync_det #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] rise
);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [STAGES-1:0] sync_reg;
         logic              dly_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_reg <= '0;
               dly_reg  <= 1'b0;
            end else begin
               sync_reg <= {sync_reg[STAGES-2:0], async_in[gi]};
               dly_reg  <= sync_reg[STAGES-1];
            end
         end

         // Both terms come straight from flops, so the pulse is glitch-free.
         assign rise[gi] = sync_reg[STAGES-1] & ~dly_reg;
      end
   endgenerate

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of a slow clock in system clocks, counts its edges,
// and reports lock (stable in-tolerance periods) and loss of the clock.
module clk_period_meter
   import clk_period_meter_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int EXP_PER = DEF_EXP_PER,
   parameter int TOL     = DEF_TOL,
   parameter int LOCK_N  = DEF_LOCK_N,
   parameter int TMO_MAX = DEF_TMO_MAX
) (
   input  logic                CLK_50MHz,
   input  logic                Res,
   clk_period_meter_if.master  mon
);

   localparam int               OK_W    = $clog2(LOCK_N + 1);
   localparam logic [CNT_W:0]   PER_LO  = (CNT_W+1)'(tol_lo(EXP_PER, TOL));
   localparam logic [CNT_W:0]   PER_HI  = (CNT_W+1)'(tol_hi(EXP_PER, TOL));
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TMO_MAX);
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TMO_MAX - 1);
   localparam logic [OK_W-1:0]  OK_FULL = OK_W'(LOCK_N);

   logic             clk_rise;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W:0]   cnt_p1;
   logic             in_tol;
   logic [OK_W-1:0]  ok_next;
   logic [7:0]       led_reg;

   meter_state_t     state_reg;
   logic [CNT_W-1:0] period_reg;
   logic             period_vld_reg;
   logic             lock_reg;
   logic             timeout_reg;
   logic [OK_W-1:0]  ok_cnt_reg;

   edge_sync_det #(
      .WIDTH  (1),
      .STAGES (2)
   ) u_sync (
      .clk      (CLK_50MHz),
      .rst_n    (Res),
      .async_in (mon.CLK_IN),
      .rise     (clk_rise)
   );

   // cnt holds clocks since the last edge minus one, so the period is cnt+1;
   // the extra bit keeps the compare correct even at the top of the range.
   assign cnt_p1  = {1'b0, cnt_reg} + (CNT_W+1)'(1);
   assign in_tol  = (cnt_p1 >= PER_LO) && (cnt_p1 <= PER_HI);
   assign ok_next = (ok_cnt_reg == OK_FULL) ? OK_FULL : ok_cnt_reg + OK_W'(1);

   always_ff @(posedge CLK_50MHz or negedge Res) begin
      if (!Res) begin
         cnt_reg <= '0;
         led_reg <= '0;
      end else if (clk_rise) begin
         cnt_reg <= '0;
         led_reg <= led_reg + 8'd1;
      end else if (cnt_reg != CNT_MAX) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK_50MHz or negedge Res) begin
      if (!Res) begin
         state_reg      <= WAIT_FIRST;
         period_reg     <= '0;
         period_vld_reg <= 1'b0;
         lock_reg       <= 1'b0;
         timeout_reg    <= 1'b0;
         ok_cnt_reg     <= '0;
      end else begin
         period_vld_reg <= 1'b0;
         case (state_reg)
            WAIT_FIRST: begin
               if (clk_rise) state_reg <= MEASURE;
            end
            MEASURE: begin
               // An edge on the timeout cycle still counts as a valid period.
               if (clk_rise) begin
                  period_reg     <= cnt_p1[CNT_W-1:0];
                  period_vld_reg <= 1'b1;
                  if (in_tol) begin
                     ok_cnt_reg <= ok_next;
                     lock_reg   <= (ok_next == OK_FULL);
                  end else begin
                     ok_cnt_reg <= '0;
                     lock_reg   <= 1'b0;
                  end
               end else if (cnt_reg == CNT_PRE) begin
                  state_reg   <= LOST;
                  timeout_reg <= 1'b1;
                  lock_reg    <= 1'b0;
                  ok_cnt_reg  <= '0;
               end
            end
            LOST: begin
               // The interval ending here spans the outage, so it is not reported.
               if (clk_rise) begin
                  state_reg   <= MEASURE;
                  timeout_reg <= 1'b0;
               end
            end
            default: state_reg <= WAIT_FIRST;
         endcase
      end
   end

   assign mon.LED        = led_reg;
   assign mon.PERIOD     = period_reg;
   assign mon.PERIOD_VLD = period_vld_reg;
   assign mon.LOCK       = lock_reg;
   assign mon.TIMEOUT    = timeout_reg;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed plus randomized bench for clk_period_meter; expectations come from
// a period-level model of rises, gaps, tolerance runs and the edge count.
module tb_clk_period_meter;

   localparam int EXP   = 250;
   localparam int TOLR  = 2;
   localparam int LOCKN = 4;
   localparam int TMO   = 1023;

   logic CLK_50MHz = 1'b0;
   logic Res       = 1'b0;

   clk_period_meter_if bus ();

   clk_period_meter dut (
      .CLK_50MHz (CLK_50MHz),
      .Res       (Res),
      .mon       (bus)
   );

   always #10 CLK_50MHz = ~CLK_50MHz;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor: count PERIOD_VLD pulses and capture PERIOD/LOCK in that same cycle.
   int          vld_n = 0;
   logic [15:0] vld_per = '0;
   logic        vld_lock = 1'b0;
   always @(negedge CLK_50MHz) begin
      if (bus.PERIOD_VLD === 1'b1) begin
         vld_n    <= vld_n + 1;
         vld_per  <= bus.PERIOD;
         vld_lock <= bus.LOCK;
      end
   end

   // Period-level reference model.
   bit have_ref;
   int good_run;
   int led_m;
   int period_hold;
   int gap_prev;

   task automatic model_reset();
      have_ref    = 1'b0;
      good_run    = 0;
      led_m       = 0;
      period_hold = 0;
      gap_prev    = 0;
   endtask

   task automatic model_rise(input int gap, output bit rep, output int per, output bit lk);
      rep = have_ref && (gap <= TMO);
      per = 0;
      if (rep) begin
         per = gap;
         if (gap >= EXP - TOLR && gap <= EXP + TOLR)
            good_run = (good_run < LOCKN) ? good_run + 1 : LOCKN;
         else
            good_run = 0;
      end else begin
         good_run = 0;
      end
      lk       = (good_run >= LOCKN);
      have_ref = 1'b1;
      led_m    = (led_m + 1) % 256;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge CLK_50MHz);
      #5;
   endtask

   task automatic check_zero(input string tag);
      chk(tag, {5'd0, bus.LED, bus.PERIOD, bus.PERIOD_VLD, bus.LOCK, bus.TIMEOUT}, 32'd0);
   endtask

   task automatic check_rise(input int v0, input bit rep, input int per, input bit lk);
      chk("vld_count", vld_n - v0, rep ? 1 : 0);
      if (rep) begin
         chk("period_at_vld", vld_per, per);
         chk("lock_at_vld", vld_lock, lk);
         period_hold = per;
      end
      chk("period", bus.PERIOD, period_hold);
      chk("lock", bus.LOCK, lk);
      chk("led", bus.LED, led_m);
      chk("timeout", bus.TIMEOUT, 0);
   endtask

   // One rising edge of CLK_IN followed by p system clocks until the next one.
   task automatic do_period(input int p);
      int v0;
      bit rep;
      int per;
      bit lk;
      v0 = vld_n;
      model_rise(gap_prev, rep, per, lk);
      bus.CLK_IN = 1'b1;
      wait_clks(p / 2);
      bus.CLK_IN = 1'b0;
      wait_clks(p - p / 2);
      gap_prev = p;
      check_rise(v0, rep, per, lk);
   endtask

   // One rising edge, then CLK_IN held low until TIMEOUT (bounded).
   task automatic lose_clock();
      int v0;
      int n;
      bit rep;
      int per;
      bit lk;
      v0 = vld_n;
      model_rise(gap_prev, rep, per, lk);
      bus.CLK_IN = 1'b1;
      wait_clks(100);
      bus.CLK_IN = 1'b0;
      n = 100;
      while (bus.TIMEOUT !== 1'b1 && n < 2000) begin
         wait_clks(1);
         n++;
      end
      chk("vld_count_before_loss", vld_n - v0, rep ? 1 : 0);
      if (rep) begin
         chk("period_at_vld", vld_per, per);
         chk("lock_at_vld", vld_lock, lk);
         period_hold = per;
      end
      // 1023 clocks after the edge cycle, which itself trails the rise by 2-3 clocks.
      chk("timeout_latency", n, (n >= 1025 && n <= 1027) ? n : 1026);
      chk("timeout_set", bus.TIMEOUT, 1);
      chk("lock_after_loss", bus.LOCK, 0);
      chk("period_hold_loss", bus.PERIOD, period_hold);
      chk("led_loss", bus.LED, led_m);
      good_run = 0;
      gap_prev = 1000000;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.CLK_IN = 1'b0;
      model_reset();

      // 1: reset held for 12 us with CLK_IN toggling.
      #3;
      for (int i = 0; i < 600; i++) begin
         if (i % 50 == 0) bus.CLK_IN = ~bus.CLK_IN;
         wait_clks(1);
         if (i % 20 == 0) check_zero("reset_hold");
      end
      bus.CLK_IN = 1'b0;
      wait_clks(5);
      Res = 1'b1;
      wait_clks(5);
      check_zero("after_release");

      // 2: nominal 200 kHz, lock on 4th reported period, LED reaches 10.
      for (int i = 0; i < 10; i++) do_period(250);
      chk("led_after_10", bus.LED, 10);

      // 4: one long period breaks lock, then relock.
      do_period(255);
      for (int i = 0; i < 5; i++) do_period(250);

      // Randomized periods around nominal, in and out of tolerance.
      for (int i = 0; i < 16; i++) do_period(int'($urandom_range(244, 256)));
      for (int i = 0; i < 5; i++) do_period(250);
      chk("locked_before_loss", bus.LOCK, 1);

      // 5: clock loss, recovery without a report, then normal reports.
      lose_clock();
      for (int i = 0; i < 6; i++) do_period(250);

      // 6: asynchronous reset mid-period while locked, then scenario 2 again.
      chk("locked_before_reset", bus.LOCK, 1);
      bus.CLK_IN = 1'b1;
      wait_clks(60);
      #3 Res = 1'b0;
      #1 check_zero("async_reset");
      model_reset();
      wait_clks(3);
      bus.CLK_IN = 1'b0;
      wait_clks(3);
      check_zero("reset_mid_period");
      Res = 1'b1;
      wait_clks(4);
      for (int i = 0; i < 10; i++) do_period(250);
      chk("led_after_10_rerun", bus.LED, 10);

      // 3: 300 short random periods after a fresh reset, LED wraps to 44.
      Res = 1'b0;
      wait_clks(3);
      model_reset();
      Res = 1'b1;
      wait_clks(3);
      for (int i = 0; i < 300; i++) do_period(int'($urandom_range(12, 40)));
      chk("led_wrap_300", bus.LED, 44);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
